// File: rtl/fm_audio_pkg.sv
// Shared constants for the FM audio path: default sample width, word-select
// polarity and the I2S framing modes.
package fm_audio_pkg;

  localparam int DEFAULT_DW = 16;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  typedef enum logic {
    ALIGN_I2S = 1'b0,
    ALIGN_LJ  = 1'b1
  } align_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator: divides clk down to the bit clock and flags the
// cycle in which the bit clock is about to fall.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIVW-1:0] div_reg;
  logic            bclk_reg;
  logic            wrap;

  assign wrap = (div_reg == DIVW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= '0;
      bclk_reg <= 1'b0;
    end else begin
      div_reg <= wrap ? '0 : div_reg + DIVW'(1);
      if (wrap) bclk_reg <= ~bclk_reg;
    end
  end

  assign bclk = bclk_reg;
  // Strobe is high in the cycle whose closing edge drives the bit clock low.
  assign fall = wrap & bclk_reg;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: single-entry holding buffer, frame register and
// MSB-first serializer supporting standard I2S and left-justified framing.
module i2s_tx
  import fm_audio_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] audio_l,
  input  logic [DW-1:0] audio_r,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          ws_align,
  output logic          i2s_clk,
  output logic          i2s_ws,
  output logic          i2s_dout,
  output logic          frame_start,
  output logic          underrun
);

  localparam int FW = 2 * DW;
  localparam int KW = $clog2(FW);

  logic          fall;
  logic          bclk;

  logic [DW-1:0] buf_l_reg;
  logic [DW-1:0] buf_r_reg;
  logic          buf_full_reg;
  logic          ready_reg;
  logic [FW-1:0] frame_reg;
  logic [KW-1:0] slot_reg;
  align_t        align_reg;
  logic          ws_reg;
  logic          dout_reg;
  logic          frame_start_reg;
  logic          underrun_reg;

  logic [KW-1:0] slot_next;
  logic          load;
  logic          accept;
  logic [FW-1:0] frame_next;
  align_t        align_next;
  logic [KW-1:0] idx_lj;
  logic [KW-1:0] idx_std;
  logic          bit_next;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .fall (fall)
  );

  always_comb begin
    slot_next  = (slot_reg == KW'(FW - 1)) ? '0 : slot_reg + KW'(1);
    load       = fall && (slot_next == '0);
    accept     = din_valid && ready_reg;
    frame_next = frame_reg;
    align_next = align_reg;
    // The load sees the buffer as it was before any same-cycle write.
    if (load) begin
      align_next = align_t'(ws_align);
      if (buf_full_reg) frame_next = {buf_l_reg, buf_r_reg};
    end
    idx_lj  = KW'(FW - 1) - slot_next;
    idx_std = idx_lj + KW'(1);
    // Standard framing lags one slot: slot 0 carries the prior frame's LSB.
    if (align_next == ALIGN_LJ)
      bit_next = frame_next[idx_lj];
    else if (slot_next == '0)
      bit_next = frame_reg[0];
    else
      bit_next = frame_next[idx_std];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_l_reg       <= '0;
      buf_r_reg       <= '0;
      buf_full_reg    <= 1'b0;
      ready_reg       <= 1'b1;
      frame_reg       <= '0;
      slot_reg        <= KW'(FW - 1);
      align_reg       <= ALIGN_I2S;
      ws_reg          <= WS_RIGHT;
      dout_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      frame_start_reg <= load;
      underrun_reg    <= load && !buf_full_reg;
      if (fall) begin
        slot_reg  <= slot_next;
        frame_reg <= frame_next;
        align_reg <= align_next;
        ws_reg    <= (slot_next >= KW'(DW)) ? WS_RIGHT : WS_LEFT;
        dout_reg  <= bit_next;
      end
      if (accept) begin
        buf_l_reg    <= audio_l;
        buf_r_reg    <= audio_r;
        buf_full_reg <= 1'b1;
        ready_reg    <= 1'b0;
      end else if (load && buf_full_reg) begin
        buf_full_reg <= 1'b0;
        ready_reg    <= 1'b1;
      end
    end
  end

  assign din_ready   = ready_reg;
  assign i2s_clk     = bclk;
  assign i2s_ws      = ws_reg;
  assign i2s_dout    = dout_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a frame-level reference model predicts every serial slot
// and handshake/status output; a monitor samples like an I2S receiver.
module tb_i2s_tx;

  localparam int DW      = 16;
  localparam int CLK_DIV = 4;
  localparam int FW      = 2 * DW;
  localparam int BIT     = 2 * CLK_DIV;
  localparam int FRAME   = FW * BIT;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] audio_l;
  logic [DW-1:0] audio_r;
  logic          din_valid;
  logic          din_ready;
  logic          ws_align;
  logic          i2s_clk;
  logic          i2s_ws;
  logic          i2s_dout;
  logic          frame_start;
  logic          underrun;

  int total = 0;
  int bad   = 0;

  i2s_tx #(
    .DW      (DW),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .ws_align    (ws_align),
    .i2s_clk     (i2s_clk),
    .i2s_ws      (i2s_ws),
    .i2s_dout    (i2s_dout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset, frames loaded every FRAME
  // edges starting at edge BIT, one slot per bit period.
  int            m_e = 0;
  logic          m_full;
  logic          m_ready;
  logic [DW-1:0] m_l, m_r;
  logic [FW-1:0] m_frame;
  logic          exp_fs, exp_ur;
  logic [1:0]    exp_q[$];
  bit            started = 0;

  always @(posedge clk) begin
    logic prev_lsb;
    logic b;
    if (rst) begin
      m_e     = 0;
      m_full  = 1'b0;
      m_ready = 1'b1;
      m_frame = '0;
      exp_fs  = 1'b0;
      exp_ur  = 1'b0;
      exp_q.delete();
      started = 1;
    end else begin
      m_e++;
      exp_fs = 1'b0;
      exp_ur = 1'b0;
      if (m_e >= BIT && ((m_e - BIT) % FRAME) == 0) begin
        exp_fs   = 1'b1;
        exp_ur   = !m_full;
        prev_lsb = m_frame[0];
        if (m_full) begin
          m_frame = {m_l, m_r};
          m_full  = 1'b0;
        end
        for (int k = 0; k < FW; k++) begin
          if (ws_align) b = m_frame[FW-1-k];
          else if (k == 0) b = prev_lsb;
          else b = m_frame[FW-k];
          exp_q.push_back({(k >= DW), b});
        end
      end
      if (din_valid && m_ready) begin
        m_full = 1'b1;
        m_l    = audio_l;
        m_r    = audio_r;
      end
      m_ready = !m_full;
    end
  end

  // Monitor: per-cycle status checks plus receiver-style sampling on bclk rise.
  bit   seen_fall = 0;
  logic prev_bclk = 1'b0;

  always @(negedge clk) begin
    logic [1:0] e;
    if (started) begin
      check("i2s_clk", {31'd0, i2s_clk}, {31'd0, 1'((m_e / CLK_DIV) % 2)});
      check("din_ready", {31'd0, din_ready}, {31'd0, m_ready});
      check("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
      check("underrun", {31'd0, underrun}, {31'd0, exp_ur});
      if (m_e == 0) begin
        seen_fall = 0;
        check("reset_ws", {31'd0, i2s_ws}, 32'd1);
        check("reset_dout", {31'd0, i2s_dout}, 32'd0);
      end else begin
        if (prev_bclk && !i2s_clk) seen_fall = 1;
        if (!prev_bclk && i2s_clk && seen_fall) begin
          if (exp_q.size() == 0) begin
            check("slot_expected", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("slot_ws", {31'd0, i2s_ws}, {31'd0, e[1]});
            check("slot_dout", {31'd0, i2s_dout}, {31'd0, e[0]});
          end
        end
      end
      prev_bclk = i2s_clk;
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n = 0;
    @(negedge clk);
    din_valid = 1'b1;
    audio_l   = l;
    audio_r   = r;
    while (!din_ready && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("send_accepted", {31'd0, din_ready}, 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    int g = 0;
    while (m_e + 1 != target && g < 4 * FRAME) begin
      @(negedge clk);
      g++;
    end
    check("wait_edge_reached", m_e + 1, target);
  endtask

  initial begin
    bit acc_pending;
    rst       = 1'b1;
    din_valid = 1'b0;
    audio_l   = '0;
    audio_r   = '0;
    ws_align  = 1'b1;

    // Left-justified: one pair, then two frames with no new data.
    do_reset(3);
    send(16'hA5C3, 16'h0F0F);
    repeat (2 * FRAME + 20) @(negedge clk);
    $display("phase lj_single done: total=%0d", total);

    // Standard framing with back-to-back writes.
    ws_align = 1'b0;
    do_reset(2);
    send(16'hA5C3, 16'h0F0F);
    send(DW'($urandom), DW'($urandom));
    repeat (2 * FRAME + 20) @(negedge clk);
    $display("phase std_b2b done: total=%0d", total);

    // Write lands exactly on the frame-1 load edge with an empty buffer.
    ws_align = 1'b1;
    do_reset(2);
    wait_edge(BIT + FRAME);
    din_valid = 1'b1;
    audio_l   = 16'h1234;
    audio_r   = 16'h8001;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    $display("phase load_collision done: total=%0d", total);

    // Randomized traffic with mid-frame alignment changes.
    do_reset(1);
    acc_pending = 0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clk);
      if (acc_pending) din_valid = 1'b0;
      acc_pending = 0;
      if (!din_valid && $urandom_range(0, 99) < 3) begin
        din_valid = 1'b1;
        audio_l   = DW'($urandom);
        audio_r   = DW'($urandom);
      end
      if (din_valid && din_ready) acc_pending = 1;
      if ($urandom_range(0, 199) == 0) ws_align = ~ws_align;
    end
    din_valid = 1'b0;
    $display("phase random done: total=%0d", total);

    // Reset pulsed at slot 10 of frame 0, then restart.
    do_reset(2);
    send(DW'($urandom), DW'($urandom));
    wait_edge(BIT + 10 * BIT + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(DW'($urandom), DW'($urandom));
    repeat (FRAME + 40) @(negedge clk);
    $display("phase mid_reset done: total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
